// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths and dump state encoding for the register file
package cpu_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG = 32;
  typedef enum logic {DUMP_IDLE, DUMP_ACTIVE} dump_state_t;
endpackage

// File: rtl/regfile_rd_bypass.sv
// regfile_rd_bypass: combinational read of one address with r0 forced to zero and write-through bypass
module regfile_rd_bypass #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] entry,
  input  logic              we,
  input  logic [ADDR_W-1:0] wn,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  assign q = (addr == '0) ? '0 : (we && wn == addr) ? d : entry;
endmodule

// File: rtl/regfile_dp.sv
// regfile_dp: 2-read/1-write register file with r0 hardwired to zero and a valid/ready dump sequencer
module regfile_dp #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rna,
  input  logic [ADDR_W-1:0] rnb,
  output logic [DATA_W-1:0] qa,
  output logic [DATA_W-1:0] qb,
  input  logic              we,
  input  logic [ADDR_W-1:0] wn,
  input  logic [DATA_W-1:0] d,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data
);
  import cpu_pkg::*;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  dump_state_t state;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
    end else if (we && wn != '0) begin
      mem[wn] <= d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DUMP_IDLE;
      dump_idx <= '0;
    end else if (state == DUMP_IDLE) begin
      if (dump_start) begin
        state <= DUMP_ACTIVE;
        dump_idx <= '0;
      end
    end else if (dump_ready) begin
      state <= (&dump_idx) ? DUMP_IDLE : DUMP_ACTIVE;
      dump_idx <= (&dump_idx) ? '0 : dump_idx + 1'b1;
    end
  end
  assign dump_busy = (state == DUMP_ACTIVE);
  assign dump_valid = (state == DUMP_ACTIVE);
  regfile_rd_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_a (
    .addr(rna), .entry(mem[rna]), .we(we), .wn(wn), .d(d), .q(qa)
  );
  regfile_rd_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_b (
    .addr(rnb), .entry(mem[rnb]), .we(we), .wn(wn), .d(d), .q(qb)
  );
  regfile_rd_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_dump (
    .addr(dump_idx), .entry(mem[dump_idx]), .we(we), .wn(wn), .d(d), .q(dump_data)
  );
endmodule

// File: tb/tb_regfile_dp.sv
// tb_regfile_dp: directed self-checking bench for regfile_dp
module tb_regfile_dp;
  logic        clk = 0;
  logic        rst;
  logic [4:0]  rna, rnb, wn;
  logic [31:0] qa, qb, d;
  logic        we;
  logic        dump_start, dump_busy, dump_valid, dump_ready;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  int tests = 0;
  int fails = 0;
  regfile_dp dut (
    .clk(clk), .rst(rst), .rna(rna), .rnb(rnb), .qa(qa), .qb(qb),
    .we(we), .wn(wn), .d(d), .dump_start(dump_start), .dump_busy(dump_busy),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx),
    .dump_data(dump_data)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1; rna = 0; rnb = 0; wn = 0; d = 0; we = 0;
    dump_start = 0; dump_ready = 0;
    tick();
    rst = 0;
    #1;
    check("rst_busy", {31'd0, dump_busy}, 32'd0);
    check("rst_valid", {31'd0, dump_valid}, 32'd0);
    check("rst_idx", {27'd0, dump_idx}, 32'd0);
    check("rst_data", dump_data, 32'd0);
    for (int i = 0; i < 32; i++) begin
      rna = 5'(i); rnb = 5'(31 - i);
      #1;
      check("rst_qa", qa, 32'd0);
      check("rst_qb", qb, 32'd0);
    end
    we = 1; wn = 5; d = 32'hDEADBEEF;
    tick();
    we = 0; rna = 5;
    #1;
    check("wr5_qa", qa, 32'hDEADBEEF);
    we = 1; wn = 0; d = 32'h12345678; rna = 0;
    #1;
    check("wr0_bypass_qa", qa, 32'd0);
    tick();
    we = 0;
    #1;
    check("wr0_qa", qa, 32'd0);
    we = 1; wn = 7; d = 32'hA5A5A5A5; rna = 7; rnb = 7;
    #1;
    check("byp_qa", qa, 32'hA5A5A5A5);
    check("byp_qb", qb, 32'hA5A5A5A5);
    we = 0;
    #1;
    check("nobyp_qa", qa, 32'd0);
    check("nobyp_qb", qb, 32'd0);
    we = 1;
    tick();
    we = 0;
    #1;
    check("wr7_qa", qa, 32'hA5A5A5A5);
    for (int i = 1; i < 32; i++) begin
      we = 1; wn = 5'(i); d = i * 32'h01010101;
      tick();
    end
    we = 0;
    dump_ready = 1; dump_start = 1;
    tick();
    dump_start = 0;
    for (int k = 0; k < 32; k++) begin
      dump_start = (k == 5 || k == 31);
      #1;
      check("dump_valid", {31'd0, dump_valid}, 32'd1);
      check("dump_busy", {31'd0, dump_busy}, 32'd1);
      check("dump_idx", {27'd0, dump_idx}, k);
      check("dump_data", dump_data, k * 32'h01010101);
      tick();
      dump_start = 0;
    end
    check("end_busy", {31'd0, dump_busy}, 32'd0);
    check("end_valid", {31'd0, dump_valid}, 32'd0);
    check("end_idx", {27'd0, dump_idx}, 32'd0);
    tick();
    check("end_stay_idle", {31'd0, dump_busy}, 32'd0);
    dump_start = 1;
    tick();
    dump_start = 0;
    tick(); tick(); tick();
    check("bp_idx3", {27'd0, dump_idx}, 32'd3);
    dump_ready = 0;
    for (int c = 0; c < 4; c++) begin
      we = (c == 1); wn = 3; d = 32'hCAFEF00D;
      #1;
      check("bp_hold_idx", {27'd0, dump_idx}, 32'd3);
      check("bp_hold_valid", {31'd0, dump_valid}, 32'd1);
      check("bp_data", dump_data, (c >= 1) ? 32'hCAFEF00D : 32'h03030303);
      tick();
      we = 0;
    end
    dump_ready = 1;
    #1;
    check("bp_accept_data", dump_data, 32'hCAFEF00D);
    tick();
    check("bp_next_idx", {27'd0, dump_idx}, 32'd4);
    check("bp_next_data", dump_data, 32'h04040404);
    repeat (6) tick();
    check("pre_rst_idx", {27'd0, dump_idx}, 32'd10);
    rst = 1; we = 1; wn = 9; d = 32'hFFFFFFFF; dump_start = 1;
    tick();
    rst = 0; we = 0; dump_start = 0;
    #1;
    check("abort_valid", {31'd0, dump_valid}, 32'd0);
    check("abort_busy", {31'd0, dump_busy}, 32'd0);
    check("abort_idx", {27'd0, dump_idx}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      rna = 5'(i); rnb = 5'(i);
      #1;
      check("abort_qa", qa, 32'd0);
      check("abort_qb", qb, 32'd0);
    end
    tick();
    check("abort_stay_idle", {31'd0, dump_busy}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
